// File: rtl/stream_demultiplexer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ready_valid_i / ndata_i                                           |
// | Handshake interfaces shared by the stream demultiplexer.          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+

interface ready_valid_i #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport m (output data, output valid, input ready);
    modport s (input data, input valid, output ready);
endinterface

interface ndata_i #(
    parameter type T          = logic [7:0],
    parameter int  NUM_TUPLES = 1
);
    T     [NUM_TUPLES-1:0] data;
    logic [NUM_TUPLES-1:0] keep;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport m (output data, output keep, output last, output valid, input ready);
    modport s (input data, input keep, input last, input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/stream_demultiplexer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_demultiplexer                                              |
// | Routes whole packets to one of NUM_STREAMS outputs through a      |
// | single registered stage; optional STF_DEMUX_BROADCAST_EN.         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+

module stream_demultiplexer #(
    parameter int  NUM_STREAMS = 4,
    parameter type TUPLE_T     = logic [7:0],
    parameter int  NUM_TUPLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    ready_valid_i.s     select,
    ndata_i.s           in,
    ndata_i.m           out [NUM_STREAMS],
    output logic [31:0] dropped_pkts
);

    localparam int               SEL_W         = $clog2(NUM_STREAMS) + 1;
    localparam logic [SEL_W-1:0] c_num_streams = SEL_W'(NUM_STREAMS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_STREAMS-1:0]  r_dest;
    logic [NUM_STREAMS-1:0]  w_dest_nxt;
    logic [NUM_STREAMS-1:0]  r_pending;
    logic [NUM_STREAMS-1:0]  w_pending_left;
    logic [NUM_STREAMS-1:0]  w_out_ready;
    logic [NUM_STREAMS-1:0]  w_onehot;
    TUPLE_T [NUM_TUPLES-1:0] r_data;
    logic [NUM_TUPLES-1:0]   r_keep;
    logic                    r_last;
    logic [31:0]             r_dropped;
    logic                    w_sel_ready;
    logic                    w_in_ready;
    logic                    w_load;
    logic                    w_drop_done;

    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_out
        assign out[gi].valid   = r_pending[gi] & ~rst;
        assign out[gi].data    = r_data;
        assign out[gi].keep    = r_keep;
        assign out[gi].last    = r_last;
        assign w_out_ready[gi] = out[gi].ready;
    end

    assign w_onehot     = NUM_STREAMS'(1) << select.data;
    assign select.ready = w_sel_ready;
    assign in.ready     = w_in_ready;
    assign dropped_pkts = r_dropped;

    // The register is free once every output still owed the beat takes it this cycle.
    always_comb begin
        w_pending_left = r_pending & ~w_out_ready;
        w_state_nxt    = r_state;
        w_dest_nxt     = r_dest;
        w_sel_ready    = 1'b0;
        w_in_ready     = 1'b0;
        w_load         = 1'b0;
        w_drop_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sel_ready = ~rst;
                if (select.valid && !rst) begin
                    if (select.data < c_num_streams) begin
                        w_dest_nxt  = w_onehot;
                        w_state_nxt = ST_ROUTE;
                    end
`ifdef STF_DEMUX_BROADCAST_EN
                    else if (select.data == c_num_streams) begin
                        w_dest_nxt  = '1;
                        w_state_nxt = ST_ROUTE;
                    end
`endif
                    else begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_ROUTE: begin
                w_in_ready = ~rst & ~(|w_pending_left);
                if (in.valid && w_in_ready) begin
                    w_load = 1'b1;
                    if (in.last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                w_in_ready = ~rst;
                if (in.valid && w_in_ready && in.last) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_dropped <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_load ? r_dest : w_pending_left;
            if (w_drop_done && (r_dropped != 32'hFFFF_FFFF)) begin
                r_dropped <= r_dropped + 32'd1;
            end
        end
    end

    // Payload and destination need no reset: they are qualified by pending and state.
    always_ff @(posedge clk) begin
        r_dest <= w_dest_nxt;
        if (w_load) begin
            r_data <= in.data;
            r_keep <= in.keep;
            r_last <= in.last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_demultiplexer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stream_demultiplexer                                           |
// | Directed plus random packets scored against a packet-level model. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+

module tb_stream_demultiplexer;

    localparam int NS = 4;
    localparam int NT = 2;
    localparam int SW = $clog2(NS) + 1;

    typedef logic [7:0] tuple_t;
    typedef struct packed {
        tuple_t [NT-1:0] data;
        logic [NT-1:0]   keep;
        logic            last;
    } beat_t;
    typedef struct {
        int dest;
        int len;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dropped_pkts;

    ready_valid_i #(.W(SW)) sel_if ();
    ndata_i #(.T(tuple_t), .NUM_TUPLES(NT)) in_if ();
    ndata_i #(.T(tuple_t), .NUM_TUPLES(NT)) out_if [NS] ();

    logic [NS-1:0]   o_valid;
    logic [NS-1:0]   o_ready;
    logic [NS-1:0]   o_last;
    tuple_t [NT-1:0] o_data [NS];
    logic [NT-1:0]   o_keep [NS];

    for (genvar g = 0; g < NS; g++) begin : g_tap
        assign o_valid[g]      = out_if[g].valid;
        assign o_last[g]       = out_if[g].last;
        assign o_data[g]       = out_if[g].data;
        assign o_keep[g]       = out_if[g].keep;
        assign out_if[g].ready = o_ready[g];
    end

    stream_demultiplexer #(
        .NUM_STREAMS(NS),
        .TUPLE_T    (tuple_t),
        .NUM_TUPLES (NT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .select      (sel_if),
        .in          (in_if),
        .out         (out_if),
        .dropped_pkts(dropped_pkts)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: which outputs still owe a beat, and the packet in progress.
    bit          m_in_pkt;
    bit          m_drop_pkt;
    bit [NS-1:0] m_dest;
    bit          m_has [NS];
    beat_t       m_slot [NS];
    logic [31:0] m_drops;

    // Producer state.
    pkt_t  pkt_q [$];
    bit    sel_done;
    bit    have_beat;
    bit    in_pending;
    int    beat_idx;
    beat_t cur_beat;
    int    gap_pct;
    bit    rand_ready;
    int    ready_pct;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit model_busy();
        bit b = (pkt_q.size() > 0);
        for (int i = 0; i < NS; i++) b |= m_has[i];
        return b;
    endfunction

    task automatic drive_inputs();
        if (rand_ready)
            for (int i = 0; i < NS; i++) o_ready[i] = ($urandom_range(99) < ready_pct);
        if (!have_beat && pkt_q.size() > 0) begin
            cur_beat.data = (NT*8)'($urandom);
            cur_beat.keep = NT'($urandom_range(1, (1 << NT) - 1));
            cur_beat.last = (beat_idx == pkt_q[0].len - 1);
            have_beat     = 1'b1;
        end
        sel_if.valid = 1'b0;
        in_if.valid  = 1'b0;
        if (pkt_q.size() > 0) begin
            sel_if.data = SW'(pkt_q[0].dest);
            if (!sel_done) begin
                sel_if.valid = 1'b1;
            end else begin
                if (!in_pending) in_pending = ($urandom_range(99) >= gap_pct);
                in_if.valid = in_pending;
            end
        end
        in_if.data = cur_beat.data;
        in_if.keep = cur_beat.keep;
        in_if.last = cur_beat.last;
    endtask

    task automatic check_and_update();
        bit    exp_sel_rdy;
        bit    exp_in_rdy;
        bit    sel_hs;
        bit    in_hs;
        beat_t beat;
        int    d;
        exp_sel_rdy = !rst && !m_in_pkt;
        exp_in_rdy  = 1'b0;
        if (!rst && m_in_pkt) begin
            exp_in_rdy = 1'b1;
            if (!m_drop_pkt)
                for (int i = 0; i < NS; i++) if (m_has[i] && !o_ready[i]) exp_in_rdy = 1'b0;
        end
        chk("select_ready", 64'(sel_if.ready), 64'(exp_sel_rdy));
        chk("in_ready", 64'(in_if.ready), 64'(exp_in_rdy));
        chk("dropped_pkts", 64'(dropped_pkts), 64'(m_drops));
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("out%0d_valid", i), 64'(o_valid[i]), 64'(m_has[i] && !rst));
            if (m_has[i] && !rst)
                chk($sformatf("out%0d_beat", i), 64'({o_data[i], o_keep[i], o_last[i]}), 64'(m_slot[i]));
        end

        sel_hs = sel_if.valid && exp_sel_rdy;
        in_hs  = in_if.valid && exp_in_rdy;
        beat   = '{data: in_if.data, keep: in_if.keep, last: in_if.last};
        if (rst) begin
            for (int i = 0; i < NS; i++) m_has[i] = 1'b0;
            m_in_pkt = 1'b0;
            m_drops  = '0;
        end else begin
            for (int i = 0; i < NS; i++) if (m_has[i] && o_ready[i]) m_has[i] = 1'b0;
            if (in_hs) begin
                if (m_drop_pkt) begin
                    if (beat.last) begin
                        if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 32'd1;
                        m_in_pkt = 1'b0;
                    end
                end else begin
                    for (int i = 0; i < NS; i++) if (m_dest[i]) begin
                        m_has[i]  = 1'b1;
                        m_slot[i] = beat;
                    end
                    if (beat.last) m_in_pkt = 1'b0;
                end
            end
            if (sel_hs) begin
                d          = int'(sel_if.data);
                m_in_pkt   = 1'b1;
                m_drop_pkt = 1'b0;
                if (d < NS) m_dest = NS'(1) << d;
`ifdef STF_DEMUX_BROADCAST_EN
                else if (d == NS) m_dest = '1;
`endif
                else m_drop_pkt = 1'b1;
            end
            if (sel_hs) sel_done = 1'b1;
            if (in_hs) begin
                in_pending = 1'b0;
                have_beat  = 1'b0;
                if (beat.last) begin
                    void'(pkt_q.pop_front());
                    sel_done = 1'b0;
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        #1;
        check_and_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (model_busy() && n < budget) begin
            step();
            n++;
        end
        total++;
        assert (n < budget) passed++;
        else $error("FAIL drain_timeout observed=%0d expected_below=%0d", n, budget);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        sel_if.valid = 1'b0;
        sel_if.data  = '0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.keep   = '0;
        in_if.last   = 1'b0;
        o_ready      = '1;
        rand_ready   = 1'b0;
        ready_pct    = 100;
        gap_pct      = 0;
        sel_done     = 1'b0;
        have_beat    = 1'b0;
        in_pending   = 1'b0;
        beat_idx     = 0;
        m_in_pkt     = 1'b0;
        m_drop_pkt   = 1'b0;
        m_dest       = '0;
        m_drops      = '0;
        for (int i = 0; i < NS; i++) m_has[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        step();                         // reset values, still in reset
        rst = 1'b0;

        // Unicast 3-beat packet to out[2].
        pkt_q.push_back('{dest: 2, len: 3});
        drain(40);
        chk("unicast_no_drop", 64'(dropped_pkts), 64'd0);

        // Backpressure on out[1] during the middle of a 4-beat packet.
        pkt_q.push_back('{dest: 1, len: 4});
        for (int k = 0; k < 10; k++) begin
            o_ready = (k >= 3 && k <= 5) ? 4'b1101 : 4'b1111;
            step();
        end
        o_ready = '1;
        drain(40);

        // Back-to-back packets.
        pkt_q.push_back('{dest: 0, len: 2});
        pkt_q.push_back('{dest: 3, len: 1});
        drain(40);

        // Out-of-range select drops the packet.
        pkt_q.push_back('{dest: 7, len: 5});
        drain(40);
        step();
        chk("drop_count", 64'(dropped_pkts), 64'd1);

        // Reset during beat 2 of a 4-beat packet, then rerouted to out[3].
        pkt_q.push_back('{dest: 1, len: 4});
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sel_done        = 1'b0;
        pkt_q[0].dest   = 3;
        drain(40);
        chk("reset_clears_drops", 64'(dropped_pkts), 64'd0);

        // Select == NUM_STREAMS: broadcast when enabled, otherwise dropped.
        pkt_q.push_back('{dest: NS, len: 2});
        for (int k = 0; k < 8; k++) begin
            o_ready = (k >= 2 && k <= 3) ? 4'b1110 : 4'b1111;
            step();
        end
        o_ready = '1;
        drain(40);

        // Randomized traffic with random backpressure and input gaps.
        rand_ready = 1'b1;
        ready_pct  = 70;
        gap_pct    = 20;
        for (int p = 0; p < 40; p++)
            pkt_q.push_back('{dest: int'($urandom_range(0, (1 << SW) - 1)),
                              len: int'($urandom_range(1, 5))});
        drain(3000);
        rand_ready = 1'b0;
        o_ready    = '1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
